// File: rtl/keypad_time_entry_ctrl.sv
// Keypad time-entry controller: sequences the keypad encoder, debounces digit
// presses into a 4-digit BCD MM:SS value and hands it to the cook timer.
module keypad_time_entry_ctrl #(
    parameter int WARMUP_CYCLES = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_en,
    input  logic [3:0]  key_code,
    input  logic        start_btn,
    input  logic        clear_btn,
    input  logic        cook_done,
    output logic        enc_enable,
    output logic [15:0] time_bcd,
    output logic [2:0]  digit_count,
    output logic        key_ack,
    output logic        time_load,
    output logic        start_err,
    output logic        busy
);
    localparam logic [7:0] WARM_LAST   = 8'(WARMUP_CYCLES - 1);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_WAIT_KEY,
        S_DEBOUNCE,
        S_WAIT_RELEASE,
        S_COOKING
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [3:0]  code_reg, code_next;
    logic [15:0] time_reg, time_next;
    logic [2:0]  count_reg, count_next;
    logic        start_d_reg, clear_d_reg;
    logic        key_ack_reg, key_ack_next;
    logic        time_load_reg, time_load_next;
    logic        start_err_reg, start_err_next;
    logic        enc_enable_reg, busy_reg;
    logic        start_edge, clear_edge;
    logic        next_is_entry;

    assign start_edge = start_btn & ~start_d_reg;
    assign clear_edge = clear_btn & ~clear_d_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        code_next      = code_reg;
        time_next      = time_reg;
        count_next     = count_reg;
        key_ack_next   = 1'b0;
        time_load_next = 1'b0;
        start_err_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (entry_en) begin
                    state_next = S_WARMUP;
                    cnt_next   = 8'd0;
                end
            end
            S_COOKING: begin
                if (clear_edge || cook_done) begin
                    time_next  = 16'h0000;
                    count_next = 3'd0;
                    cnt_next   = 8'd0;
                    state_next = entry_en ? S_WARMUP : S_IDLE;
                end
            end
            default: begin
                // Entry states: door/permission loss beats clear, clear beats start,
                // and any start edge pre-empts this cycle's keypad progress.
                if (!entry_en) begin
                    state_next = S_IDLE;
                end else if (clear_edge) begin
                    time_next  = 16'h0000;
                    count_next = 3'd0;
                    cnt_next   = 8'd0;
                    state_next = S_WAIT_KEY;
                end else if (start_edge) begin
                    if (count_reg == 3'd0 || time_reg[7:4] > 4'd5) begin
                        start_err_next = 1'b1;
                    end else begin
                        time_load_next = 1'b1;
                        state_next     = S_COOKING;
                    end
                end else begin
                    case (state_reg)
                        S_WARMUP: begin
                            if (cnt_reg == WARM_LAST) begin
                                state_next = S_WAIT_KEY;
                                cnt_next   = 8'd0;
                            end else begin
                                cnt_next = cnt_reg + 8'd1;
                            end
                        end
                        S_WAIT_KEY: begin
                            if (key_code <= 4'd9) begin
                                code_next  = key_code;
                                cnt_next   = 8'd1;
                                state_next = S_DEBOUNCE;
                            end
                        end
                        S_DEBOUNCE: begin
                            if (key_code == code_reg) begin
                                if (cnt_reg == STABLE_LAST) begin
                                    if (count_reg < 3'd4) begin
                                        time_next    = {time_reg[11:0], code_reg};
                                        count_next   = count_reg + 3'd1;
                                        key_ack_next = 1'b1;
                                    end
                                    cnt_next   = 8'd0;
                                    state_next = S_WAIT_RELEASE;
                                end else begin
                                    cnt_next = cnt_reg + 8'd1;
                                end
                            end else begin
                                state_next = S_WAIT_KEY;
                            end
                        end
                        S_WAIT_RELEASE: begin
                            if (key_code == 4'hF) begin
                                if (cnt_reg == STABLE_LAST) begin
                                    cnt_next   = 8'd0;
                                    state_next = S_WAIT_KEY;
                                end else begin
                                    cnt_next = cnt_reg + 8'd1;
                                end
                            end else begin
                                cnt_next = 8'd0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    assign next_is_entry = (state_next == S_WARMUP) || (state_next == S_WAIT_KEY) ||
                           (state_next == S_DEBOUNCE) || (state_next == S_WAIT_RELEASE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 8'd0;
            code_reg       <= 4'd0;
            time_reg       <= 16'h0000;
            count_reg      <= 3'd0;
            start_d_reg    <= 1'b0;
            clear_d_reg    <= 1'b0;
            key_ack_reg    <= 1'b0;
            time_load_reg  <= 1'b0;
            start_err_reg  <= 1'b0;
            enc_enable_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            code_reg       <= code_next;
            time_reg       <= time_next;
            count_reg      <= count_next;
            start_d_reg    <= start_btn;
            clear_d_reg    <= clear_btn;
            key_ack_reg    <= key_ack_next;
            time_load_reg  <= time_load_next;
            start_err_reg  <= start_err_next;
            enc_enable_reg <= next_is_entry;
            busy_reg       <= (state_next == S_COOKING);
        end
    end

    assign enc_enable  = enc_enable_reg;
    assign time_bcd    = time_reg;
    assign digit_count = count_reg;
    assign key_ack     = key_ack_reg;
    assign time_load   = time_load_reg;
    assign start_err   = start_err_reg;
    assign busy        = busy_reg;

endmodule
